// File: rtl/memory_wb_lsu_if.sv
// Wishbone B4 classic data-memory bus between the LSU (master) and data memory (slave).
//   cyc/stb/we : cycle, strobe, write enable (master)
//   adr        : word-aligned byte address (master)
//   dat_w      : write data, lane-replicated (master)
//   sel        : byte select (master)
//   ack/err    : slave response
//   dat_r      : read data (slave)
interface memory_wb_lsu_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [XLEN-1:0]       dat_w;
  logic [XLEN/8-1:0]     sel;
  logic                  ack;
  logic                  err;
  logic [XLEN-1:0]       dat_r;

  modport master (output cyc, stb, we, adr, dat_w, sel, input ack, err, dat_r);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output ack, err, dat_r);
endinterface

// File: rtl/memory_wb_lsu.sv
// Memory stage / load-store unit. Masters data memory over Wishbone classic, stalls the
// pipeline until ack, err or timeout, and raises misaligned / access-fault exceptions.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   pc_i .. reg_write_i  : execute-stage sideband, alu_result_i is the byte address for mem ops
//   rs2_data_i           : store data; mem_read_i/mem_write_i/mem_size_i select the access
//   hold_i, flush_i      : downstream stall, kill current instruction
//   dmem                 : Wishbone master port (registered controls)
//   pc_o .. reg_write_o  : writeback sideband; mem_data_o formatted load data
//   stall_o              : combinational upstream stall
//   exc_valid_o/cause/tval : exception report accompanying instr_o
module memory_wb_lsu #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ILEN           = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_WIDTH-1:0]     pc_i,
  input  logic [ILEN-1:0]           instr_i,
  input  logic                      instr_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      reg_write_i,
  input  logic [XLEN-1:0]           alu_result_i,
  input  logic [XLEN-1:0]           rs2_data_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic [2:0]                mem_size_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  memory_wb_lsu_if.master           dmem,
  output logic [ADDR_WIDTH-1:0]     pc_o,
  output logic [ILEN-1:0]           instr_o,
  output logic                      instr_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [XLEN-1:0]           alu_result_o,
  output logic                      reg_write_o,
  output logic [XLEN-1:0]           mem_data_o,
  output logic                      stall_o,
  output logic                      exc_valid_o,
  output logic [3:0]                exc_cause_o,
  output logic [ADDR_WIDTH-1:0]     exc_tval_o
);
  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OW  = $clog2(NB);
  localparam int unsigned TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TimerLast = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     pc;
    logic [ILEN-1:0]           instr;
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]           alu;
    logic                      rw;
    logic [XLEN-1:0]           mdata;
    logic                      exc;
    logic [3:0]                cause;
    logic [ADDR_WIDTH-1:0]     tval;
  } wb_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     pc;
    logic [ILEN-1:0]           instr;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rw;
    logic [XLEN-1:0]           alu;
    logic [2:0]                size;
  } req_t;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  flush_q, flush_d;
  logic                  cyc_q, cyc_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [XLEN-1:0]       dat_q, dat_d;
  logic [NB-1:0]         sel_q, sel_d;
  req_t                  req_q, req_d;
  logic [XLEN-1:0]       rsp_data_q, rsp_data_d;
  logic                  rsp_fault_q, rsp_fault_d;
  wb_t                   wb_q, wb_d;

  logic                  is_mem, size_legal, aligned, start, done, wait_fault, to_hit;
  logic                  fin, fin_fault, kill;
  logic [XLEN-1:0]       fin_data, st_data, lane, ld_data;
  logic [NB-1:0]         mask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [OW-1:0]         req_off;

  assign addr    = ADDR_WIDTH'(alu_result_i);
  assign is_mem  = instr_valid_i && (mem_read_i || mem_write_i);
  assign start   = (state_q == StIdle) && is_mem && size_legal && aligned && !hold_i && !flush_i;
  assign to_hit  = TimeoutEn && (timer_q == TimerLast);
  assign done    = (state_q == StWait) && (dmem.ack || dmem.err || to_hit);
  // Ack wins over err; a timeout only counts when the slave said nothing.
  assign wait_fault = !dmem.ack && (dmem.err || to_hit);
  assign stall_o = start || ((state_q == StWait) && !done) || (state_q == StResp);

  always_comb begin
    case (mem_size_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_legal = 1'b1;
      3'b011, 3'b110:                         size_legal = (XLEN == 64);
      default:                                size_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (mem_size_i[1:0])
      2'd0: begin aligned = 1'b1;                        mask = NB'(1);
                  st_data = {NB{rs2_data_i[7:0]}}; end
      2'd1: begin aligned = (alu_result_i[0] == 1'b0);   mask = NB'(3);
                  st_data = {(NB/2){rs2_data_i[15:0]}}; end
      2'd2: begin aligned = (alu_result_i[1:0] == 2'b00); mask = NB'(15);
                  st_data = {(XLEN/32){rs2_data_i[31:0]}}; end
      default: begin aligned = (alu_result_i[2:0] == 3'b000); mask = '1;
                  st_data = rs2_data_i; end
    endcase
  end

  // Load formatting uses the latched request, since upstream may move on once done.
  assign req_off = req_q.alu[OW-1:0];
  assign lane    = dmem.dat_r >> {req_off, 3'b000};
  always_comb begin
    case (req_q.size)
      3'b000:  ld_data = XLEN'($signed(lane[7:0]));
      3'b001:  ld_data = XLEN'($signed(lane[15:0]));
      3'b010:  ld_data = XLEN'($signed(lane[31:0]));
      3'b100:  ld_data = XLEN'(lane[7:0]);
      3'b101:  ld_data = XLEN'(lane[15:0]);
      3'b110:  ld_data = XLEN'(lane[31:0]);
      default: ld_data = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    flush_d     = flush_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    req_d       = req_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    wb_d        = wb_q;
    fin         = 1'b0;
    fin_fault   = rsp_fault_q;
    fin_data    = rsp_data_q;
    kill        = flush_q || flush_i;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWait;
          timer_d = '0;
          cyc_d   = 1'b1;
          we_d    = mem_write_i;
          adr_d   = addr & ~ADDR_WIDTH'(NB - 1);
          dat_d   = st_data;
          sel_d   = mask << alu_result_i[OW-1:0];
          req_d   = '{pc: pc_i, instr: instr_i, rd: rd_addr_i, rw: reg_write_i,
                      alu: alu_result_i, size: mem_size_i};
        end else if (!hold_i) begin
          wb_d       = '0;
          wb_d.pc    = pc_i;
          wb_d.instr = instr_i;
          wb_d.rd    = rd_addr_i;
          wb_d.alu   = alu_result_i;
          wb_d.valid = instr_valid_i && !flush_i;
          wb_d.rw    = instr_valid_i && !flush_i && reg_write_i;
          if (is_mem && !flush_i && (!size_legal || !aligned)) begin
            wb_d.exc   = 1'b1;
            wb_d.rw    = 1'b0;
            wb_d.tval  = addr;
            // Illegal size outranks misalignment: it is an access fault.
            wb_d.cause = !size_legal ? (mem_write_i ? 4'd7 : 4'd5)
                                     : (mem_write_i ? 4'd6 : 4'd4);
          end
        end
      end
      StWait: begin
        if (flush_i) flush_d = 1'b1;
        if (!done && (timer_q != '1)) timer_d = timer_q + 1'b1;
        if (done) begin
          cyc_d = 1'b0;
          if (!hold_i) begin
            fin       = 1'b1;
            fin_fault = wait_fault;
            fin_data  = ld_data;
            state_d   = StIdle;
          end else begin
            rsp_data_d  = ld_data;
            rsp_fault_d = wait_fault;
            state_d     = StResp;
          end
        end
      end
      StResp: begin
        if (flush_i) flush_d = 1'b1;
        if (!hold_i) begin
          fin     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fin) begin
      flush_d    = 1'b0;
      wb_d       = '0;
      wb_d.pc    = req_q.pc;
      wb_d.instr = req_q.instr;
      wb_d.rd    = req_q.rd;
      wb_d.alu   = req_q.alu;
      wb_d.valid = !kill;
      if (!kill) begin
        if (fin_fault) begin
          wb_d.exc   = 1'b1;
          wb_d.cause = we_q ? 4'd7 : 4'd5;
          wb_d.tval  = ADDR_WIDTH'(req_q.alu);
        end else begin
          wb_d.rw    = req_q.rw;
          wb_d.mdata = we_q ? '0 : fin_data;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      flush_q     <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      req_q       <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      flush_q     <= flush_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      req_q       <= req_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      wb_q        <= wb_d;
    end
  end

  assign dmem.cyc      = cyc_q;
  assign dmem.stb      = cyc_q;
  assign dmem.we       = we_q;
  assign dmem.adr      = adr_q;
  assign dmem.dat_w    = dat_q;
  assign dmem.sel      = sel_q;
  assign pc_o          = wb_q.pc;
  assign instr_o       = wb_q.instr;
  assign instr_valid_o = wb_q.valid;
  assign rd_addr_o     = wb_q.rd;
  assign alu_result_o  = wb_q.alu;
  assign reg_write_o   = wb_q.rw;
  assign mem_data_o    = wb_q.mdata;
  assign exc_valid_o   = wb_q.exc;
  assign exc_cause_o   = wb_q.cause;
  assign exc_tval_o    = wb_q.tval;
endmodule

// File: tb/tb_memory_wb_lsu.sv
// Directed bench for memory_wb_lsu: an XLEN=32 and an XLEN=64 instance (both with a 4-cycle
// timeout) driven from shared sideband signals with a per-instance instr_valid.
module tb_memory_wb_lsu;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] pc, instr;
  logic        valid32, valid64, rw, mem_rd, mem_wr, hold, flush;
  logic [4:0]  rd;
  logic [63:0] alu, rs2;
  logic [2:0]  size;

  logic [31:0] o32_pc, o32_instr, o32_alu, o32_mem, o32_tval;
  logic        o32_valid, o32_rw, stall32, o32_exc;
  logic [4:0]  o32_rd;
  logic [3:0]  o32_cause;
  logic [31:0] o64_pc, o64_instr, o64_tval;
  logic [63:0] o64_alu, o64_mem;
  logic        o64_valid, o64_rw, stall64, o64_exc;
  logic [4:0]  o64_rd;
  logic [3:0]  o64_cause;

  int checks = 0;
  int errors = 0;
  int st, cy;

  // Slave models: mode 0 acks, 1 errs, 2 stays silent; response after wait_n wait states.
  int          mode32 = 0, wait32 = 0, cnt32, mode64 = 0, wait64 = 0, cnt64;
  logic [31:0] rdata32 = '0;
  logic [63:0] rdata64 = '0;

  memory_wb_lsu_if #(.XLEN(32), .ADDR_WIDTH(32)) bus32 ();
  memory_wb_lsu_if #(.XLEN(64), .ADDR_WIDTH(32)) bus64 ();

  assign bus32.ack   = bus32.cyc && bus32.stb && (mode32 == 0) && (cnt32 == wait32);
  assign bus32.err   = bus32.cyc && bus32.stb && (mode32 == 1) && (cnt32 == wait32);
  assign bus32.dat_r = rdata32;
  assign bus64.ack   = bus64.cyc && bus64.stb && (mode64 == 0) && (cnt64 == wait64);
  assign bus64.err   = bus64.cyc && bus64.stb && (mode64 == 1) && (cnt64 == wait64);
  assign bus64.dat_r = rdata64;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt32 <= 0;
      cnt64 <= 0;
    end else begin
      cnt32 <= (bus32.cyc && bus32.stb) ? cnt32 + 1 : 0;
      cnt64 <= (bus64.cyc && bus64.stb) ? cnt64 + 1 : 0;
    end
  end

  always #5 clk = ~clk;

  memory_wb_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) u32 (
    .clk_i(clk), .rst_ni(rst_ni), .pc_i(pc), .instr_i(instr), .instr_valid_i(valid32),
    .rd_addr_i(rd), .reg_write_i(rw), .alu_result_i(alu[31:0]), .rs2_data_i(rs2[31:0]),
    .mem_read_i(mem_rd), .mem_write_i(mem_wr), .mem_size_i(size), .hold_i(hold),
    .flush_i(flush), .dmem(bus32), .pc_o(o32_pc), .instr_o(o32_instr),
    .instr_valid_o(o32_valid), .rd_addr_o(o32_rd), .alu_result_o(o32_alu),
    .reg_write_o(o32_rw), .mem_data_o(o32_mem), .stall_o(stall32), .exc_valid_o(o32_exc),
    .exc_cause_o(o32_cause), .exc_tval_o(o32_tval)
  );

  memory_wb_lsu #(.XLEN(64), .TIMEOUT_CYCLES(4)) u64 (
    .clk_i(clk), .rst_ni(rst_ni), .pc_i(pc), .instr_i(instr), .instr_valid_i(valid64),
    .rd_addr_i(rd), .reg_write_i(rw), .alu_result_i(alu), .rs2_data_i(rs2),
    .mem_read_i(mem_rd), .mem_write_i(mem_wr), .mem_size_i(size), .hold_i(hold),
    .flush_i(flush), .dmem(bus64), .pc_o(o64_pc), .instr_o(o64_instr),
    .instr_valid_o(o64_valid), .rd_addr_o(o64_rd), .alu_result_o(o64_alu),
    .reg_write_o(o64_rw), .mem_data_o(o64_mem), .stall_o(stall64), .exc_valid_o(o64_exc),
    .exc_cause_o(o64_cause), .exc_tval_o(o64_tval)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input bit w64, input bit r, input bit w, input logic [2:0] sz,
                        input logic [63:0] a, input logic [63:0] d, input bit rwi);
    valid32 = !w64;
    valid64 = w64;
    mem_rd  = r;
    mem_wr  = w;
    size    = sz;
    alu     = a;
    rs2     = d;
    rw      = rwi;
    pc      = pc + 32'd4;
    instr   = instr + 32'h100;
    rd      = rd + 5'd1;
  endtask

  // Counts stall and cyc cycles until stall drops, then passes the completing edge.
  task automatic wait_done(input bit w64, output int stalls, output int cycs);
    bit seen;
    seen   = 1'b0;
    stalls = 0;
    cycs   = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (w64 ? bus64.cyc : bus32.cyc) cycs++;
      if (w64 ? stall64 : stall32) stalls++;
      else seen = 1'b1;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL done_timeout: observed stall after 40 cycles expected release");
    end
    @(posedge clk);
    #1;
    valid32 = 1'b0;
    valid64 = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; valid32 = 1'b0; valid64 = 1'b0; pc = 32'h40; instr = 32'h3; rd = '0;
    rw = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = '0; alu = '0; rs2 = '0;
    hold = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc32", bus32.cyc, 0);
    chk("rst_valid32", o32_valid, 0);
    chk("rst_cyc64", bus64.cyc, 0);
    chk("rst_exc64", o64_exc, 0);
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // SW with two wait states
    mode32 = 0; wait32 = 2;
    set_op(0, 0, 1, 3'b010, 64'h100, 64'hDEADBEEF, 0);
    wait_done(0, st, cy);
    chk("sw_stall", st, 3);
    chk("sw_cyc", cy, 3);
    chk("sw_adr", bus32.adr, 32'h100);
    chk("sw_sel", bus32.sel, 4'b1111);
    chk("sw_we", bus32.we, 1);
    chk("sw_dat", bus32.dat_w, 32'hDEADBEEF);
    chk("sw_valid", o32_valid, 1);
    chk("sw_rw", o32_rw, 0);
    chk("sw_exc", o32_exc, 0);
    chk("sw_pc", o32_pc, pc);

    // LB / LBU at 0x103, zero-wait slave
    wait32 = 0; rdata32 = 32'h8000_0000;
    set_op(0, 1, 0, 3'b000, 64'h103, 64'h0, 1);
    wait_done(0, st, cy);
    chk("lb_stall", st, 1);
    chk("lb_sel", bus32.sel, 4'b1000);
    chk("lb_adr", bus32.adr, 32'h100);
    chk("lb_data", o32_mem, 32'hFFFF_FF80);
    chk("lb_rw", o32_rw, 1);
    chk("lb_rd", o32_rd, rd);
    set_op(0, 1, 0, 3'b100, 64'h103, 64'h0, 1);
    wait_done(0, st, cy);
    chk("lbu_data", o32_mem, 32'h0000_0080);

    // SB replicated across lanes
    set_op(0, 0, 1, 3'b000, 64'h102, 64'hA5, 0);
    wait_done(0, st, cy);
    chk("sb_sel", bus32.sel, 4'b0100);
    chk("sb_dat", bus32.dat_w, 32'hA5A5A5A5);

    // LH misaligned: single-cycle pass, no bus cycle
    set_op(0, 1, 0, 3'b001, 64'h101, 64'h0, 1);
    wait_done(0, st, cy);
    chk("lh_stall", st, 0);
    chk("lh_cyc", cy, 0);
    chk("lh_exc", o32_exc, 1);
    chk("lh_cause", o32_cause, 4);
    chk("lh_tval", o32_tval, 32'h101);
    chk("lh_rw", o32_rw, 0);

    // LD is illegal at XLEN=32
    set_op(0, 1, 0, 3'b011, 64'h100, 64'h0, 1);
    wait_done(0, st, cy);
    chk("ld32_cyc", cy, 0);
    chk("ld32_exc", o32_exc, 1);
    chk("ld32_cause", o32_cause, 5);

    // LWU at 0x104 on XLEN=64
    mode64 = 0; wait64 = 0; rdata64 = 64'hF000_0001_1234_5678;
    set_op(1, 1, 0, 3'b110, 64'h104, 64'h0, 1);
    wait_done(1, st, cy);
    chk("lwu_stall", st, 1);
    chk("lwu_sel", bus64.sel, 8'hF0);
    chk("lwu_adr", bus64.adr, 32'h100);
    chk("lwu_data", o64_mem, 64'h0000_0000_F000_0001);
    chk("lwu_exc", o64_exc, 0);

    // SW to a silent slave: timeout after 4 WAIT cycles
    mode32 = 2;
    set_op(0, 0, 1, 3'b010, 64'h200, 64'h55, 0);
    wait_done(0, st, cy);
    chk("to_cyc", cy, 4);
    chk("to_stall", st, 4);
    chk("to_exc", o32_exc, 1);
    chk("to_cause", o32_cause, 7);
    chk("to_tval", o32_tval, 32'h200);

    // LW answered by err
    mode32 = 1; wait32 = 1; rdata32 = 32'hFFFF_FFFF;
    set_op(0, 1, 0, 3'b010, 64'h204, 64'h0, 1);
    wait_done(0, st, cy);
    chk("err_stall", st, 2);
    chk("err_cause", o32_cause, 5);
    chk("err_data", o32_mem, 0);
    chk("err_rw", o32_rw, 0);

    // Ack while downstream holds for 3 cycles
    mode32 = 0; wait32 = 0; rdata32 = 32'h1234_5678;
    set_op(0, 1, 0, 3'b010, 64'h300, 64'h0, 1);
    @(posedge clk);
    #1;
    chk("hold_cyc_on", bus32.cyc, 1);
    hold = 1'b1;
    @(negedge clk);
    chk("hold_done_stall", stall32, 0);
    @(posedge clk);
    #1;
    valid32 = 1'b0;
    chk("hold_cyc_off", bus32.cyc, 0);
    chk("hold_exc_kept", o32_exc, 1);
    @(negedge clk);
    chk("hold_resp_stall", stall32, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    hold = 1'b0;
    chk("hold_data_kept", o32_mem, 0);
    @(posedge clk);
    #1;
    chk("hold_data", o32_mem, 32'h1234_5678);
    chk("hold_exc", o32_exc, 0);
    chk("hold_valid", o32_valid, 1);
    chk("hold_rw", o32_rw, 1);

    // Flush during WAIT: bus finishes, result is a bubble
    wait32 = 2;
    set_op(0, 1, 0, 3'b010, 64'h400, 64'h0, 1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_done(0, st, cy);
    chk("flush_valid", o32_valid, 0);
    chk("flush_rw", o32_rw, 0);
    chk("flush_exc", o32_exc, 0);
    chk("flush_pc", o32_pc, pc);

    // Reset in the middle of WAIT
    mode32 = 2;
    set_op(0, 0, 1, 3'b010, 64'h500, 64'h1, 0);
    @(posedge clk);
    #1;
    chk("rstw_cyc_on", bus32.cyc, 1);
    #2;
    rst_ni = 1'b0;
    valid32 = 1'b0;
    #1;
    chk("rstw_cyc", bus32.cyc, 0);
    chk("rstw_stb", bus32.stb, 0);
    chk("rstw_pc", o32_pc, 0);
    chk("rstw_sel", bus32.sel, 0);
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Non-memory op after reset passes in one cycle
    set_op(0, 0, 0, 3'b000, 64'h1234, 64'h0, 1);
    wait_done(0, st, cy);
    chk("alu_stall", st, 0);
    chk("alu_result", o32_alu, 32'h1234);
    chk("alu_rw", o32_rw, 1);
    chk("alu_valid", o32_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
